// File: rtl/vend_if.sv
// vend_if: coin, selection and cancel pulses into the vending controller,
// and the registered credit/dispense/change/reject status coming back out.
interface vend_if;
  logic       coin_half;
  logic       coin_one;
  logic       sel_a;
  logic       sel_b;
  logic       cancel;
  logic [5:0] coin_sum;
  logic       vend_a;
  logic       vend_b;
  logic       change_tick;
  logic       coin_reject;
  logic       busy;

  modport master (
    output coin_half, coin_one, sel_a, sel_b, cancel,
    input  coin_sum, vend_a, vend_b, change_tick, coin_reject, busy
  );

  modport slave (
    input  coin_half, coin_one, sel_a, sel_b, cancel,
    output coin_sum, vend_a, vend_b, change_tick, coin_reject, busy
  );
endinterface

// File: rtl/vend_ctrl.sv
// vend_ctrl: vending controller tracking credit in 0.5-yuan units, dispensing A/B and paying change.
// Optional idle auto-refund in COLLECT is compiled in when VEND_TIMEOUT_EN is defined.
module vend_ctrl #(
  parameter int PRICE_A     = 5,
  parameter int PRICE_B     = 10,
  parameter int TIMEOUT_CYC = 1000
) (
  input logic   clk,
  input logic   rst,
  vend_if.slave bus
);

  typedef enum logic [1:0] {IDLE, COLLECT, VEND, CHANGE} state_t;

  localparam logic [5:0] PRICE_A_U = 6'(PRICE_A);
  localparam logic [5:0] PRICE_B_U = 6'(PRICE_B);

  state_t     state;
  logic [5:0] coin_sum_q;
  logic       vend_a_q;
  logic       vend_b_q;
  logic       change_tick_q;
  logic       coin_reject_q;
  logic       busy_q;
  logic       item_b;

  logic       coin_any;
  logic [6:0] sum_add;
  logic       sel_a_ok;
  logic       sel_b_ok;
  logic [5:0] vend_price;
  logic [5:0] vend_rem;

  // Bit 6 of the widened sum flags a coin cycle that would push credit past 63.
  assign coin_any   = bus.coin_half | bus.coin_one;
  assign sum_add    = {1'b0, coin_sum_q} + {5'b0, bus.coin_one, bus.coin_half};
  assign sel_a_ok   = bus.sel_a && (coin_sum_q >= PRICE_A_U);
  assign sel_b_ok   = bus.sel_b && (coin_sum_q >= PRICE_B_U);
  assign vend_price = item_b ? PRICE_B_U : PRICE_A_U;
  assign vend_rem   = coin_sum_q - vend_price;

`ifdef VEND_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYC - 1);
  logic [TW-1:0] timer;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      coin_sum_q    <= '0;
      vend_a_q      <= 1'b0;
      vend_b_q      <= 1'b0;
      change_tick_q <= 1'b0;
      coin_reject_q <= 1'b0;
      busy_q        <= 1'b0;
      item_b        <= 1'b0;
`ifdef VEND_TIMEOUT_EN
      timer         <= '0;
`endif
    end else begin
      vend_a_q      <= 1'b0;
      vend_b_q      <= 1'b0;
      change_tick_q <= 1'b0;
      coin_reject_q <= 1'b0;
`ifdef VEND_TIMEOUT_EN
      timer         <= '0;
`endif
      unique case (state)
        IDLE: begin
          if (coin_any) begin
            if (sum_add[6]) begin
              coin_reject_q <= 1'b1;
            end else begin
              coin_sum_q <= sum_add[5:0];
              state      <= COLLECT;
            end
          end
        end

        // A winning cancel/selection returns any coin arriving in the same cycle.
        COLLECT: begin
          if (bus.cancel) begin
            state         <= CHANGE;
            busy_q        <= 1'b1;
            coin_reject_q <= coin_any;
          end else if (sel_a_ok) begin
            state         <= VEND;
            item_b        <= 1'b0;
            busy_q        <= 1'b1;
            coin_reject_q <= coin_any;
          end else if (sel_b_ok) begin
            state         <= VEND;
            item_b        <= 1'b1;
            busy_q        <= 1'b1;
            coin_reject_q <= coin_any;
          end else begin
            if (coin_any) begin
              if (sum_add[6]) coin_reject_q <= 1'b1;
              else            coin_sum_q    <= sum_add[5:0];
            end
`ifdef VEND_TIMEOUT_EN
            if (!(coin_any || bus.sel_a || bus.sel_b)) begin
              if (timer == TIMER_LAST) begin
                state  <= CHANGE;
                busy_q <= 1'b1;
              end else begin
                timer <= timer + 1'b1;
              end
            end
`endif
          end
        end

        VEND: begin
          coin_reject_q <= coin_any;
          vend_a_q      <= ~item_b;
          vend_b_q      <= item_b;
          coin_sum_q    <= vend_rem;
          busy_q        <= (vend_rem != '0);
          state         <= (vend_rem != '0) ? CHANGE : IDLE;
        end

        // One tick per half-yuan; leave on the cycle that pays the last one.
        CHANGE: begin
          coin_reject_q <= coin_any;
          if (coin_sum_q != '0) begin
            change_tick_q <= 1'b1;
            coin_sum_q    <= coin_sum_q - 6'd1;
          end
          if (coin_sum_q <= 6'd1) begin
            state  <= IDLE;
            busy_q <= 1'b0;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

  assign bus.coin_sum    = coin_sum_q;
  assign bus.vend_a      = vend_a_q;
  assign bus.vend_b      = vend_b_q;
  assign bus.change_tick = change_tick_q;
  assign bus.coin_reject = coin_reject_q;
  assign bus.busy        = busy_q;

endmodule

// File: tb/tb_vend_ctrl.sv
// tb_vend_ctrl: directed and random stimulus for vend_ctrl; a credit/refund reference model
// predicts every cycle's outputs into a queue that an independent monitor checks.
module tb_vend_ctrl;

  localparam int PRICE_A = 5;
  localparam int PRICE_B = 10;
`ifdef VEND_TIMEOUT_EN
  localparam int TO_CYC = 20;
`else
  localparam int TO_CYC = 1000;
`endif

  typedef struct {
    int         cyc;
    int         scen;
    logic [5:0] sum;
    logic       va;
    logic       vb;
    logic       tk;
    logic       rej;
    logic       busy;
  } exp_t;

  logic clk;
  logic rst;
  vend_if vif ();

  vend_ctrl #(
    .PRICE_A    (PRICE_A),
    .PRICE_B    (PRICE_B),
    .TIMEOUT_CYC(TO_CYC)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(vif)
  );

  exp_t expq[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  int   scen  = 0;

  // Reference model: credit, pending item (0 none, 1 A, 2 B), refund-in-progress, idle age.
  int   m_credit = 0;
  int   m_item   = 0;
  bit   m_refund = 0;
  int   m_idle   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic bit modelBusy();
    return (m_item != 0) || m_refund;
  endfunction

  task automatic modelStep(input bit h, input bit o, input bit sa, input bit sb,
                           input bit cn, input bit r);
    exp_t e;
    int   add;
    int   prev_idle;
    bit   coin;
    bit   collecting;
    add        = int'(h) + 2 * int'(o);
    coin       = h | o;
    collecting = (m_credit > 0) && !modelBusy();
    prev_idle  = m_idle;
    m_idle     = 0;
    e.va = 0; e.vb = 0; e.tk = 0; e.rej = 0;
    if (r) begin
      m_credit = 0; m_item = 0; m_refund = 0;
    end else if (m_item != 0) begin
      e.rej    = coin;
      m_credit = m_credit - ((m_item == 1) ? PRICE_A : PRICE_B);
      e.va     = (m_item == 1);
      e.vb     = (m_item == 2);
      m_item   = 0;
      m_refund = (m_credit > 0);
    end else if (m_refund) begin
      e.rej = coin;
      if (m_credit > 0) begin
        e.tk = 1; m_credit = m_credit - 1;
      end
      m_refund = (m_credit > 0);
    end else if (collecting && cn) begin
      e.rej = coin; m_refund = 1;
    end else if (collecting && sa && m_credit >= PRICE_A) begin
      e.rej = coin; m_item = 1;
    end else if (collecting && sb && m_credit >= PRICE_B) begin
      e.rej = coin; m_item = 2;
    end else begin
      if (coin) begin
        if (m_credit + add > 63) e.rej = 1;
        else                     m_credit = m_credit + add;
      end
`ifdef VEND_TIMEOUT_EN
      if (collecting && !(coin || sa || sb)) begin
        if (prev_idle == TO_CYC - 1) m_refund = 1;
        else                         m_idle = prev_idle + 1;
      end
`endif
    end
    e.cyc  = cyc;
    e.scen = scen;
    e.sum  = 6'(m_credit);
    e.busy = modelBusy();
    expq.push_back(e);
  endtask

  task automatic applyStimulus(input bit h, input bit o, input bit sa, input bit sb,
                               input bit cn, input bit r);
    @(negedge clk);
    vif.coin_half = h;
    vif.coin_one  = o;
    vif.sel_a     = sa;
    vif.sel_b     = sb;
    vif.cancel    = cn;
    rst           = r;
    modelStep(h, o, sa, sb, cn, r);
    cyc++;
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, 0, 0, 0);
  endtask

  task automatic drainToIdle();
    for (int i = 0; i < 200 && (m_credit != 0 || modelBusy()); i++)
      applyStimulus(0, 0, 0, 0, !modelBusy(), 0);
  endtask

  task automatic checkOutput(input exp_t e);
    total++;
    if (vif.coin_sum !== e.sum || vif.vend_a !== e.va || vif.vend_b !== e.vb ||
        vif.change_tick !== e.tk || vif.coin_reject !== e.rej || vif.busy !== e.busy) begin
      bad++;
      $display("[TB] FAIL cycle %0d scen %0d outputs: got sum=%0d va=%0b vb=%0b tick=%0b rej=%0b busy=%0b, need sum=%0d va=%0b vb=%0b tick=%0b rej=%0b busy=%0b",
               e.cyc, e.scen, vif.coin_sum, vif.vend_a, vif.vend_b, vif.change_tick,
               vif.coin_reject, vif.busy, e.sum, e.va, e.vb, e.tk, e.rej, e.busy);
    end
  endtask

  // Monitor: every cycle the DUT presents a fresh registered output set.
  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (expq.size() > 0) begin
        e = expq.pop_front();
        checkOutput(e);
      end
    end
  end

  initial begin
    rst = 1'b1;
    vif.coin_half = 0; vif.coin_one = 0; vif.sel_a = 0; vif.sel_b = 0; vif.cancel = 0;

    scen = 0;
    applyStimulus(0, 0, 0, 0, 0, 1);
    applyStimulus(0, 0, 0, 0, 0, 1);
    idleCycles(2);

    // Three 1-yuan coins buy A with 0.5 yuan change.
    scen = 1;
    repeat (3) applyStimulus(0, 1, 0, 0, 0, 0);
    applyStimulus(0, 0, 1, 0, 0, 0);
    idleCycles(4);

    // Both coins in one cycle, then an unaffordable B.
    scen = 2;
    applyStimulus(1, 1, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 1, 0, 0);
    idleCycles(2);
    drainToIdle();

    // Credit ceiling at 63.
    scen = 3;
    repeat (31) applyStimulus(0, 1, 0, 0, 0, 0);
    applyStimulus(0, 1, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0, 0);
    drainToIdle();
    idleCycles(2);

    // Cancel with a same-cycle coin refunds 7 ticks.
    scen = 4;
    repeat (3) applyStimulus(0, 1, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0, 0);
    applyStimulus(0, 1, 0, 0, 1, 0);
    idleCycles(10);

    // Reset while the third change tick is showing.
    scen = 5;
    repeat (3) applyStimulus(0, 1, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 1, 0);
    idleCycles(3);
    applyStimulus(0, 0, 0, 0, 0, 1);
    idleCycles(6);

    // Coins and selections while vending are rejected/ignored; B with change.
    scen = 6;
    repeat (6) applyStimulus(0, 1, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 1, 0, 0);
    applyStimulus(1, 1, 1, 1, 1, 0);
    applyStimulus(0, 1, 1, 0, 0, 0);
    idleCycles(3);
    drainToIdle();

`ifdef VEND_TIMEOUT_EN
    // Idle credit is auto-refunded.
    scen = 7;
    applyStimulus(0, 1, 0, 0, 0, 0);
    idleCycles(26);
`endif

    scen = 8;
    for (int i = 0; i < 3000; i++) begin
      bit h, o, sa, sb, cn, r;
      h  = ($urandom_range(99) < 20);
      o  = ($urandom_range(99) < 25);
      sa = ($urandom_range(99) < 8);
      sb = ($urandom_range(99) < 8);
      cn = ($urandom_range(99) < 3);
      r  = ($urandom_range(299) == 0);
      applyStimulus(h, o, sa, sb, cn, r);
    end
    idleCycles(2);

    repeat (3) @(negedge clk);
    if (expq.size() != 0) begin
      total++;
      bad++;
      $display("[TB] FAIL drain: got %0d unchecked cycles, need 0", expq.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/vend_ctrl.md
VEND_CTRL -- requirements
Module: vend_ctrl

Interface
REQ-001 The block SHALL have parameter PRICE_A, default 5, meaning item A price in 0.5-yuan units (2.5 yuan).
REQ-002 The block SHALL have parameter PRICE_B, default 10, meaning item B price in 0.5-yuan units (5.0 yuan).
REQ-003 The block SHALL have parameter TIMEOUT_CYC, default 1000, meaning idle cycles before auto-refund (used only under VEND_TIMEOUT_EN).
REQ-004 The block SHALL have port clk  input  1  the single clock; all logic on its rising edge.
REQ-005 The block SHALL have port rst  input  1  reset; synchronous and active-high.
REQ-006 The block SHALL have port coin_half  input  1  one-cycle pulse, 0.5-yuan coin inserted.
REQ-007 The block SHALL have port coin_one  input  1  one-cycle pulse, 1-yuan coin inserted.
REQ-008 The block SHALL have port sel_a / sel_b  input  1 each  one-cycle purchase request pulses.
REQ-009 The block SHALL have port cancel  input  1  one-cycle refund request pulse.
REQ-010 The block SHALL have port coin_sum  output  6  registered credit in 0.5-yuan units; feeds the display decoder directly.
REQ-011 The block SHALL have port vend_a / vend_b  output  1 each  one-cycle dispense pulses.
REQ-012 The block SHALL have port change_tick  output  1  one pulse per 0.5 yuan returned.
REQ-013 The block SHALL have port coin_reject  output  1  one-cycle pulse, inserted coin(s) returned uncredited.
REQ-014 The block SHALL have port busy  output  1  high in VEND and CHANGE states.

Function
REQ-015 The FSM SHALL have states IDLE, COLLECT, VEND, CHANGE; all outputs registered.
REQ-016 In IDLE/COLLECT, coins SHALL add coin_half*1 + coin_one*2 to coin_sum (both in one cycle = +3); IDLE moves to COLLECT on accepted credit.
REQ-017 Any coin cycle whose addition would exceed 63 SHALL be rejected whole: coin_sum unchanged, coin_reject=1 the next cycle.
REQ-018 Input priority in COLLECT SHALL be cancel > sel_a > sel_b; selections compare against the coin_sum value registered before that cycle.
REQ-019 A selection with coin_sum < price SHALL be ignored (no pulse, no state change).
REQ-020 A valid selection SHALL move to VEND; the next cycle asserts vend_x for exactly one cycle and subtracts the price from coin_sum.
REQ-021 Coins arriving in the same cycle as a valid selection or cancel, or while busy, SHALL be rejected (coin_reject pulse).
REQ-022 From VEND, remaining coin_sum > 0 SHALL go to CHANGE, otherwise to IDLE.
REQ-023 cancel in COLLECT SHALL go to CHANGE; cancel in IDLE, VEND or CHANGE SHALL be ignored.
REQ-024 In CHANGE, each cycle SHALL assert change_tick and decrement coin_sum by 1; when coin_sum reaches 0 the FSM goes to IDLE, giving exactly N consecutive ticks for credit N.
REQ-025 sel_a/sel_b while busy SHALL be ignored.

Reset
REQ-026 rst SHALL force state IDLE, coin_sum=0, vend_a=vend_b=change_tick=coin_reject=busy=0 on the next edge, aborting any vend or change in progress without emitting further pulses.
REQ-027 The timeout counter (when present) SHALL clear on rst.

Configuration
REQ-028 With macro VEND_TIMEOUT_EN defined, a counter SHALL clear on any coin, select or cancel pulse and increment in COLLECT; on reaching TIMEOUT_CYC-1 the FSM goes to CHANGE (auto-refund).
REQ-029 Without VEND_TIMEOUT_EN, the counter logic SHALL be absent and COLLECT persists indefinitely.

Verification
REQ-030 The bench SHALL run: coin_one x3 then sel_a -> coin_sum 6, then VEND with vend_a=1 for one cycle, coin_sum 1, then one change_tick, coin_sum 0, IDLE.
REQ-031 The bench SHALL run: coin_half + coin_one same cycle -> coin_sum 3; sel_b -> ignored, coin_sum stays 3, no vend_b.
REQ-032 The bench SHALL run: credit 62, then coin_one -> coin_reject=1, coin_sum stays 62; coin_half -> coin_sum 63.
REQ-033 The bench SHALL run: credit 7, then cancel + coin_one same cycle -> coin_reject=1, then exactly 7 change_tick cycles, coin_sum 0, IDLE.
REQ-034 The bench SHALL run: rst asserted during the 3rd tick of a 7-tick change -> next cycle coin_sum 0, busy 0, no further ticks.
REQ-035 The bench SHALL run, with VEND_TIMEOUT_EN and TIMEOUT_CYC=20: coin_one, then no input -> CHANGE entered after 20 cycles, 2 change_ticks.
